exec_unit: RTL and testbench
============================

Name: exec_unit

Overview:
- Execute-stage block for the 4-bit-opcode accumulator-less SCU ISA pipeline.
- Combines three functions:
  - instruction decode (control),
  - a 32-bit ALU with registered Z/N condition flags,
  - a word-addressed data memory.
- Produces the write-back value, register-write enable, branch decision and jump target.
- Sits between the ID/EX and EX/WB pipeline buffers; the register file and PC live outside this block.

Parameters:
- DATA_W, 32, datapath word width.
- ADDR_W, 8, data memory address bits; depth = 2**ADDR_W words.

Ports:
- clock  in  1  single system clock, rising-edge active.
- reset_n  in  1  asynchronous active-low reset.
- opcode  in  4  instruction opcode.
- rs_val  in  DATA_W  value of register rs; memory address and jump target.
- rt_val  in  DATA_W  value of register rt; store data and ALU operand B.
- imm_y  in  DATA_W  sign-extended immediate y.
- pc_plus_y  in  DATA_W  PC + sign-extended immediate, computed externally.
- alu_result  out  DATA_W  combinational ALU output.
- mem_rdata  out  DATA_W  combinational memory read data.
- flag_z  out  1  registered zero flag.
- flag_n  out  1  registered negative flag.
- reg_wr  out  1  register-file write enable.
- wb_data  out  DATA_W  write-back value.
- branch_taken  out  1  PC select: 1 selects jump_target.
- jump_target  out  DATA_W  next-PC value when branch_taken is 1.

Behaviour:
- Opcode decode. Fields are wbSel, regWr, aluOp, aluSrc, memWr, and the branch flags brz, brn, jump, jumpMem. All unlisted fields are 0.
  - 0000 NOP: everything 0.
  - 1111 SVPC: wbSel=00, regWr=1.
  - 1110 LD: wbSel=01, regWr=1.
  - 0011 ST: memWr=1.
  - 0100 ADD: aluOp=001, wbSel=10, regWr=1.
  - 0101 INC: aluOp=001, aluSrc=1, wbSel=10, regWr=1.
  - 0110 NEG: aluOp=010, wbSel=10, regWr=1.
  - 0111 SUB: aluOp=011, wbSel=10, regWr=1.
  - 1000 J: jump=1.
  - 1001 BRZ: brz=1.
  - 1010 JM: jump=1, jumpMem=1.
  - 1011 BRN: brn=1.
  - 0001, 0010, 1100, 1101: decode as NOP.
- ALU operands: A = rs_val; B = aluSrc ? imm_y : rt_val.
- ALU operations:
  - 001: A+B.
  - 010: 0−A (two's complement).
  - 011: A−B.
  - Any other aluOp: 0.
- ALU arithmetic is modulo 2**DATA_W; carry/overflow are discarded.
- Flags:
  - Updated only for ADD, INC, NEG and SUB, at the rising clock edge.
  - flag_z ← (alu_result==0); flag_n ← alu_result[DATA_W-1].
  - All other opcodes hold the flags.
  - Reset value of both flags is 0.
- Data memory:
  - Address = rs_val[ADDR_W-1:0]; upper bits are ignored, so addresses wrap modulo depth.
  - Read is combinational: mem_rdata = mem[addr] for any opcode.
  - Write on the rising edge when memWr=1 and reset_n=1: mem[addr] ← rt_val.
  - Writes are suppressed while reset_n=0.
  - Memory contents power up as zero and are not cleared by reset.
  - On the edge of a store, the write lands after the edge; read-during-write shows old data until the edge.
- Write-back:
  - wb_data = pc_plus_y (wbSel 00), mem_rdata (01), alu_result (10), 0 (11).
  - reg_wr = regWr.
- Branch:
  - branch_taken = jump | (brz & flag_z) | (brn & flag_n).
  - The decision uses the registered flags, i.e. the result of the most recent flag-setting instruction; it never uses the current cycle's ALU result.
  - jump_target = jumpMem ? mem_rdata : rs_val.
- Outputs during and after reset:
  - All outputs other than the flags are purely combinational; they are valid whenever inputs are stable, including during reset.
  - After reset, flag_z=0 and flag_n=0, so BRZ/BRN are not taken until a flag-setting instruction executes.
- Reset is asynchronous: asserting reset_n mid-operation clears the flags immediately. A store whose edge coincides with reset_n low is dropped.

Test Plan:
- Reset then BRZ with rs_val=0x40 -> branch_taken=0, jump_target=0x40; flag_z=0, flag_n=0.
- ADD rs=5, rt=7 -> alu_result=12, wb_data=12, reg_wr=1. After the edge, flag_z=0 and flag_n=0.
- SUB rs=3, rt=3 then BRZ rs=0x20 -> flag_z=1 and branch_taken=1.
- NEG rs=1 -> alu_result=0xFFFFFFFF, flag_n=1 after the edge; then BRN -> branch_taken=1.
- INC rs=0x7FFFFFFF, imm_y=1 -> alu_result=0x80000000 (wrap) and flag_n=1.
- ST rs=0x105, rt=0xDEAD; then LD rs=0x05 -> mem_rdata=0xDEAD (address wrap), wb_data=0xDEAD, reg_wr=1.
- JM with M[5]=0x33 -> branch_taken=1, jump_target=0x33.
- SVPC pc_plus_y=0x1234 -> wb_data=0x1234.
- ST asserted while reset_n=0 -> memory unchanged.
- Opcode 1100 -> reg_wr=0, branch_taken=0, and the flags hold.

Source files
------------

// File: rtl/exec_unit.sv
// Execute stage for the SCU ISA: opcode decode, 32-bit ALU with registered
// Z/N flags, word-addressed data memory, write-back select and branch decision.
module exec_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   input  logic [DATA_W-1:0] imm_y,
   input  logic [DATA_W-1:0] pc_plus_y,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              flag_z,
   output logic              flag_n,
   output logic              reg_wr,
   output logic [DATA_W-1:0] wb_data,
   output logic              branch_taken,
   output logic [DATA_W-1:0] jump_target
);

   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_INC  = 4'b0101;
   localparam logic [3:0] OP_NEG  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_J    = 4'b1000;
   localparam logic [3:0] OP_BRZ  = 4'b1001;
   localparam logic [3:0] OP_JM   = 4'b1010;
   localparam logic [3:0] OP_BRN  = 4'b1011;
   localparam logic [3:0] OP_LD   = 4'b1110;
   localparam logic [3:0] OP_SVPC = 4'b1111;

   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_NEG = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;

   logic [1:0]        w_wb_sel;
   logic              w_reg_wr;
   logic [2:0]        w_alu_op;
   logic              w_alu_src;
   logic              w_mem_wr;
   logic              w_brz;
   logic              w_brn;
   logic              w_jump;
   logic              w_jump_mem;
   logic [DATA_W-1:0] w_alu_b;
   logic [ADDR_W-1:0] w_addr;
   logic              r_flag_z;
   logic              r_flag_n;
   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   // Control decode; unused opcodes fall through to the all-zero NOP word.
   always_comb begin
      w_wb_sel   = 2'b00;
      w_reg_wr   = 1'b0;
      w_alu_op   = 3'b000;
      w_alu_src  = 1'b0;
      w_mem_wr   = 1'b0;
      w_brz      = 1'b0;
      w_brn      = 1'b0;
      w_jump     = 1'b0;
      w_jump_mem = 1'b0;
      case (opcode)
         OP_SVPC: begin w_wb_sel = 2'b00; w_reg_wr = 1'b1; end
         OP_LD:   begin w_wb_sel = 2'b01; w_reg_wr = 1'b1; end
         OP_ST:   w_mem_wr = 1'b1;
         OP_ADD:  begin w_alu_op = ALU_ADD; w_wb_sel = 2'b10; w_reg_wr = 1'b1; end
         OP_INC:  begin w_alu_op = ALU_ADD; w_alu_src = 1'b1; w_wb_sel = 2'b10; w_reg_wr = 1'b1; end
         OP_NEG:  begin w_alu_op = ALU_NEG; w_wb_sel = 2'b10; w_reg_wr = 1'b1; end
         OP_SUB:  begin w_alu_op = ALU_SUB; w_wb_sel = 2'b10; w_reg_wr = 1'b1; end
         OP_J:    w_jump = 1'b1;
         OP_BRZ:  w_brz = 1'b1;
         OP_JM:   begin w_jump = 1'b1; w_jump_mem = 1'b1; end
         OP_BRN:  w_brn = 1'b1;
         default: w_reg_wr = 1'b0;
      endcase
   end

   assign w_alu_b = w_alu_src ? imm_y : rt_val;
   assign w_addr  = rs_val[ADDR_W-1:0];

   // ALU; arithmetic wraps modulo 2**DATA_W.
   always_comb begin
      alu_result = {DATA_W{1'b0}};
      case (w_alu_op)
         ALU_ADD: alu_result = rs_val + w_alu_b;
         ALU_NEG: alu_result = {DATA_W{1'b0}} - rs_val;
         ALU_SUB: alu_result = rs_val - w_alu_b;
         default: alu_result = {DATA_W{1'b0}};
      endcase
   end

   // Condition flags: only the four arithmetic opcodes (non-zero aluOp) update them.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_flag_z <= 1'b0;
         r_flag_n <= 1'b0;
      end else if (w_alu_op != 3'b000) begin
         r_flag_z <= (alu_result == {DATA_W{1'b0}});
         r_flag_n <= alu_result[DATA_W-1];
      end
   end

   // Data memory write port; contents survive reset, stores under reset are dropped.
   always_ff @(posedge clock) begin
      if (reset_n && w_mem_wr) begin
         r_mem[w_addr] <= rt_val;
      end
   end

   assign mem_rdata = r_mem[w_addr];
   assign flag_z    = r_flag_z;
   assign flag_n    = r_flag_n;
   assign reg_wr    = w_reg_wr;

   // Write-back select.
   always_comb begin
      wb_data = {DATA_W{1'b0}};
      case (w_wb_sel)
         2'b00:   wb_data = pc_plus_y;
         2'b01:   wb_data = mem_rdata;
         2'b10:   wb_data = alu_result;
         default: wb_data = {DATA_W{1'b0}};
      endcase
   end

   // Branches look only at the registered flags, never at this cycle's ALU result.
   assign branch_taken = w_jump | (w_brz & r_flag_z) | (w_brn & r_flag_n);
   assign jump_target  = w_jump_mem ? mem_rdata : rs_val;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: expectations are queued as stimulus is
// driven and popped against the DUT once its outputs have settled.
module tb_exec_unit;

   localparam int SEL_ALU = 0, SEL_RDATA = 1, SEL_Z = 2, SEL_N = 3,
                  SEL_REGWR = 4, SEL_WB = 5, SEL_BR = 6, SEL_JT = 7;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       tag;
   } exp_t;

   logic        clock;
   logic        reset_n;
   logic [3:0]  opcode;
   logic [31:0] rs_val, rt_val, imm_y, pc_plus_y;
   logic [31:0] alu_result, mem_rdata, wb_data, jump_target;
   logic        flag_z, flag_n, reg_wr, branch_taken;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   exec_unit #(.DATA_W(32), .ADDR_W(8)) dut (
      .clock(clock), .reset_n(reset_n), .opcode(opcode),
      .rs_val(rs_val), .rt_val(rt_val), .imm_y(imm_y), .pc_plus_y(pc_plus_y),
      .alu_result(alu_result), .mem_rdata(mem_rdata),
      .flag_z(flag_z), .flag_n(flag_n), .reg_wr(reg_wr), .wb_data(wb_data),
      .branch_taken(branch_taken), .jump_target(jump_target)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] observe(int sel);
      case (sel)
         SEL_ALU:   return alu_result;
         SEL_RDATA: return mem_rdata;
         SEL_Z:     return {31'd0, flag_z};
         SEL_N:     return {31'd0, flag_n};
         SEL_REGWR: return {31'd0, reg_wr};
         SEL_WB:    return wb_data;
         SEL_BR:    return {31'd0, branch_taken};
         SEL_JT:    return jump_target;
         default:   return 32'hxxxx_xxxx;
      endcase
   endfunction

   task automatic expect_val(input int sel, input logic [31:0] exp, input string tag);
      exp_t e;
      e.sel = sel;
      e.exp = exp;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic check_sb();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sel);
         n_checks++;
         assert (obs === e.exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] imm, input logic [31:0] pcy);
      opcode    = op;
      rs_val    = rs;
      rt_val    = rt;
      imm_y     = imm;
      pc_plus_y = pcy;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
      tick();
      tick();
      expect_val(SEL_Z, 32'd0, "rst_flag_z");
      expect_val(SEL_N, 32'd0, "rst_flag_n");
      check_sb();
      reset_n = 1'b1;

      // BRZ straight after reset: not taken
      drive(4'b1001, 32'h40, 32'd0, 32'd0, 32'd0);
      expect_val(SEL_BR, 32'd0, "brz_after_rst");
      expect_val(SEL_JT, 32'h40, "brz_target");
      expect_val(SEL_Z, 32'd0, "brz_flag_z");
      expect_val(SEL_N, 32'd0, "brz_flag_n");
      check_sb();

      // ADD 5 + 7
      drive(4'b0100, 32'd5, 32'd7, 32'd100, 32'd0);
      expect_val(SEL_ALU, 32'd12, "add_alu");
      expect_val(SEL_WB, 32'd12, "add_wb");
      expect_val(SEL_REGWR, 32'd1, "add_regwr");
      expect_val(SEL_BR, 32'd0, "add_br");
      check_sb();
      tick();
      expect_val(SEL_Z, 32'd0, "add_flag_z");
      expect_val(SEL_N, 32'd0, "add_flag_n");
      check_sb();

      // SUB 3 - 3 sets Z, then BRZ taken, BRN not
      drive(4'b0111, 32'd3, 32'd3, 32'd0, 32'd0);
      expect_val(SEL_ALU, 32'd0, "sub_alu");
      check_sb();
      tick();
      expect_val(SEL_Z, 32'd1, "sub_flag_z");
      expect_val(SEL_N, 32'd0, "sub_flag_n");
      check_sb();
      drive(4'b1001, 32'h20, 32'd0, 32'd0, 32'd0);
      expect_val(SEL_BR, 32'd1, "brz_taken");
      expect_val(SEL_JT, 32'h20, "brz_taken_target");
      expect_val(SEL_REGWR, 32'd0, "brz_regwr");
      check_sb();
      drive(4'b1011, 32'h20, 32'd0, 32'd0, 32'd0);
      expect_val(SEL_BR, 32'd0, "brn_not_taken");
      check_sb();

      // NEG 1 -> all ones, sets N
      drive(4'b0110, 32'd1, 32'd9, 32'd0, 32'd0);
      expect_val(SEL_ALU, 32'hFFFF_FFFF, "neg_alu");
      expect_val(SEL_WB, 32'hFFFF_FFFF, "neg_wb");
      check_sb();
      tick();
      expect_val(SEL_N, 32'd1, "neg_flag_n");
      expect_val(SEL_Z, 32'd0, "neg_flag_z");
      check_sb();
      drive(4'b1011, 32'h44, 32'd0, 32'd0, 32'd0);
      expect_val(SEL_BR, 32'd1, "brn_taken");
      check_sb();
      drive(4'b1001, 32'h44, 32'd0, 32'd0, 32'd0);
      expect_val(SEL_BR, 32'd0, "brz_not_taken");
      check_sb();

      // INC uses the immediate, wraps into the sign bit
      drive(4'b0101, 32'h7FFF_FFFF, 32'h100, 32'd1, 32'd0);
      expect_val(SEL_ALU, 32'h8000_0000, "inc_alu");
      expect_val(SEL_REGWR, 32'd1, "inc_regwr");
      check_sb();
      tick();
      expect_val(SEL_N, 32'd1, "inc_flag_n");
      expect_val(SEL_Z, 32'd0, "inc_flag_z");
      check_sb();

      // ST at 0x105 lands at word 5; LD 5 reads it back
      drive(4'b0011, 32'h105, 32'hDEAD, 32'd0, 32'd0);
      expect_val(SEL_REGWR, 32'd0, "st_regwr");
      expect_val(SEL_BR, 32'd0, "st_br");
      check_sb();
      tick();
      drive(4'b1110, 32'h05, 32'd0, 32'd0, 32'd0);
      expect_val(SEL_RDATA, 32'hDEAD, "ld_rdata");
      expect_val(SEL_WB, 32'hDEAD, "ld_wb");
      expect_val(SEL_REGWR, 32'd1, "ld_regwr");
      check_sb();

      // ST 0x33 to word 5: old data visible until the edge
      drive(4'b0011, 32'h05, 32'h33, 32'd0, 32'd0);
      expect_val(SEL_RDATA, 32'hDEAD, "st_rdw_old");
      check_sb();
      tick();
      drive(4'b1010, 32'hFFFF_FF05, 32'd0, 32'd0, 32'd0);
      expect_val(SEL_BR, 32'd1, "jm_taken");
      expect_val(SEL_JT, 32'h33, "jm_target");
      expect_val(SEL_REGWR, 32'd0, "jm_regwr");
      check_sb();

      // J goes to rs
      drive(4'b1000, 32'h77, 32'd0, 32'd0, 32'd0);
      expect_val(SEL_BR, 32'd1, "j_taken");
      expect_val(SEL_JT, 32'h77, "j_target");
      check_sb();

      // SVPC
      drive(4'b1111, 32'd8, 32'd0, 32'd0, 32'h1234);
      expect_val(SEL_WB, 32'h1234, "svpc_wb");
      expect_val(SEL_REGWR, 32'd1, "svpc_regwr");
      check_sb();

      // Unused opcode 1100 acts as NOP and holds flags (N=1, Z=0)
      drive(4'b1100, 32'h10, 32'h20, 32'd0, 32'd0);
      expect_val(SEL_REGWR, 32'd0, "op1100_regwr");
      expect_val(SEL_BR, 32'd0, "op1100_br");
      expect_val(SEL_ALU, 32'd0, "op1100_alu");
      check_sb();
      tick();
      expect_val(SEL_N, 32'd1, "op1100_hold_n");
      expect_val(SEL_Z, 32'd0, "op1100_hold_z");
      check_sb();

      // Asynchronous reset clears flags; a store under reset is dropped
      drive(4'b0011, 32'h09, 32'hAAAA, 32'd0, 32'd0);
      tick();
      reset_n = 1'b0;
      #1;
      expect_val(SEL_N, 32'd0, "async_rst_n");
      expect_val(SEL_Z, 32'd0, "async_rst_z");
      check_sb();
      drive(4'b0011, 32'h09, 32'h5555, 32'd0, 32'd0);
      expect_val(SEL_JT, 32'h09, "rst_comb_target");
      check_sb();
      tick();
      expect_val(SEL_RDATA, 32'hAAAA, "st_in_rst_dropped");
      check_sb();
      reset_n = 1'b1;
      drive(4'b1110, 32'h09, 32'd0, 32'd0, 32'd0);
      expect_val(SEL_WB, 32'hAAAA, "ld_after_rst");
      check_sb();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
